ctrl_regs_axil: RTL and testbench
=================================

# ctrl_regs_axil

Parametrised AXI4-Lite slave register bank, the next generation of the fixed four-register `ctrl` peripheral. It provides NUM_RW read/write control registers with byte-strobe support and NUM_RO read-only status registers, and returns SLVERR on out-of-range accesses. It also drives one commit pulse per control register. It sits behind the PS master port (via the AXI interconnect) and feeds PL datapath blocks.

## Interface
- DATA_WIDTH, 32: AXI data width; 32 or 64 only.
- ADDR_WIDTH, 8: AXI byte-address width; must cover all implemented registers.
- NUM_RW, 8: read/write control registers, 1..64, at word indices 0..NUM_RW-1.
- NUM_RO, 4: read-only status registers, 0..64, at word indices NUM_RW..NUM_RW+NUM_RO-1.
- IRQ_W, 8: interrupt source count, 1..DATA_WIDTH; used only with CTRL_REGS_IRQ_EN.

Ports:
- ACLK  in  1  clock; all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWPROT  in  3  ignored.
- AWVALID / AWREADY  in / out  1  write-address handshake.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes.
- WVALID / WREADY  in / out  1  write-data handshake.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- BVALID / BREADY  out / in  1  write-response handshake.
- ARADDR  in  ADDR_WIDTH  read address.
- ARPROT  in  3  ignored.
- ARVALID / ARREADY  in / out  1  read-address handshake.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID / RREADY  out / in  1  read-data handshake.
- ctrl_out  out  NUM_RW*DATA_WIDTH  register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ctrl_wr_pulse  out  NUM_RW  bit k high for one cycle when register k is written.
- status_in  in  max(NUM_RO,1)*DATA_WIDTH  status words; sampled at read-address acceptance.
- irq_src  in  IRQ_W  level interrupt sources; only with CTRL_REGS_IRQ_EN.
- irq  out  1  interrupt request; only with CTRL_REGS_IRQ_EN.

## Operation
- Word index = addr[ADDR_WIDTH-1:ADDR_LSB], where ADDR_LSB = log2(DATA_WIDTH/8). Low address bits are ignored.
- Write channel:
  - AW and W are accepted independently. Each is latched, and its READY drops once its beat is held.
  - A write commits in the first cycle in which both beats are held and no B response is pending.
  - Only one write is in flight. AWREADY and WREADY stay low from commit until B handshake.
  - An in-range RW index updates only the bytes whose WSTRB is set; BRESP=00.
  - An RO index, or an index beyond the implemented registers, changes nothing; BRESP=10.
  - A write with WSTRB=0 to an RW index is OKAY, changes no data, and still pulses ctrl_wr_pulse.
- Read channel:
  - ARREADY is high whenever no R beat is pending. One read is in flight at a time.
  - RW index: returns the register value. RO index: returns the status_in word. RRESP=00.
  - Out of range: RDATA=0, RRESP=10.
- Read and write channels are independent. If a read and a write to the same register are accepted in the same cycle, the read returns the old value.
- Reset values:
  - All registers, RDATA, BRESP, RRESP, BVALID, RVALID, ctrl_wr_pulse and irq are 0.
  - AWREADY, WREADY and ARREADY are 0 during reset and go to 1 on the first edge after ARESETN deasserts.
- Reset asserted mid-transaction drops all in-flight state immediately; no response is issued.

## Timing
- Write, AW and W handshakes both at cycle T:
  - The register holds the new value and ctrl_wr_pulse[k] is high at T+1.
  - BVALID rises at T+1 and holds with BRESP stable until BREADY.
- Write with W at cycle T+n after AW at cycle T: commit occurs at T+n; the response follows at T+n+1.
- Read, AR handshake at T: RVALID and RDATA are valid at T+1 and held stable until RREADY. ARREADY is low from T+1 until R handshake completes.
- Back-to-back throughput: one write per 2 cycles and one read per 2 cycles when the master holds BREADY and RREADY high.
- All outputs are registered.

## Configuration
- CTRL_REGS_IRQ_EN defined:
  - Adds IRQ_STATUS at index NUM_RW+NUM_RO and IRQ_ENABLE at index NUM_RW+NUM_RO+1, both IRQ_W bits wide and zero-extended.
  - A status bit is set while irq_src is high and is cleared by writing 1 to it (W1C). Set wins over a simultaneous clear.
  - IRQ_ENABLE is a plain RW register.
  - irq = |(status & enable), registered: high one cycle after the condition becomes true.
- CTRL_REGS_IRQ_EN undefined: those indices are out of range (SLVERR), and the irq_src and irq ports are absent.

## Test plan
- Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back -> OKAY on every access, data matches, each ctrl_wr_pulse bit high for exactly 1 cycle.
- Write 0xAABBCCDD to index 2, then 0x11223344 with WSTRB=0101 -> reads back 0xAA22CC44.
- AW at T, W at T+3 -> commit at T+3, BVALID at T+4. BREADY held low for 5 cycles -> BVALID and BRESP stable, AWREADY stays 0.
- status_in word 0 = 0xDEADBEEF; read index NUM_RW -> 0xDEADBEEF, OKAY. Write to that index -> SLVERR, readback unchanged. Read index 0x3F -> RDATA 0, SLVERR.
- ARESETN pulled low between the AW handshake and the W beat -> no BVALID, all registers 0; after release a fresh write completes normally.
- CTRL_REGS_IRQ_EN: enable=0x01, pulse irq_src[0] -> irq=1 one cycle later. Write 0x01 to status -> irq=0. Hold irq_src[0] high through the clear -> bit stays set, irq stays 1.

Source files
------------

// File: rtl/ctrl_regs_axil_if.sv
// AXI4-Lite bus bundle for the ctrl_regs_axil register bank.
interface ctrl_regs_axil_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/ctrl_regs_axil.sv
// ctrl_regs_axil: AXI4-Lite slave register bank with NUM_RW byte-strobed
// control registers, NUM_RO status words and a per-register commit pulse.
// Optional interrupt block enabled by defining CTRL_REGS_IRQ_EN.
module ctrl_regs_axil #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_RW     = 8,
  parameter int unsigned NUM_RO     = 4,
  parameter int unsigned IRQ_W      = 8
) (
  input  logic                                               ACLK,
  input  logic                                               ARESETN,
  ctrl_regs_axil_if.slave                                    s_axi,
  output logic [NUM_RW*DATA_WIDTH-1:0]                       ctrl_out,
  output logic [NUM_RW-1:0]                                  ctrl_wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0]  status_in
`ifdef CTRL_REGS_IRQ_EN
  ,
  input  logic [IRQ_W-1:0]                                   irq_src,
  output logic                                               irq
`endif
);
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef CTRL_REGS_IRQ_EN
  localparam int unsigned IRQ_STAT_IDX = NUM_RW + NUM_RO;
  localparam int unsigned IRQ_EN_IDX   = NUM_RW + NUM_RO + 1;
`endif

  logic [DATA_WIDTH-1:0] regs_q [NUM_RW];
  logic [DATA_WIDTH-1:0] regs_d [NUM_RW];
  logic [NUM_RW-1:0]     pulse_q, pulse_d;

  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      awidx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  awready_q, wready_q, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q;

  logic                  arready_q, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic [31:0]           wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data, wr_mask, rd_data;
  logic [STRB_W-1:0]     wr_strb;

`ifdef CTRL_REGS_IRQ_EN
  logic [IRQ_W-1:0]      irq_stat_q, irq_en_q, irq_en_d, irq_clr;
  logic                  irq_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi.AWPROT, s_axi.ARPROT,
                       s_axi.AWADDR[ADDR_LSB-1:0], s_axi.ARADDR[ADDR_LSB-1:0]};

  // A beat may arrive this cycle or already be held; commit as soon as both exist.
  assign aw_hs     = s_axi.AWVALID & awready_q;
  assign w_hs      = s_axi.WVALID & wready_q;
  assign ar_hs     = s_axi.ARVALID & arready_q;
  assign commit    = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
  assign aw_held_d = ~commit & (aw_held_q | aw_hs);
  assign w_held_d  = ~commit & (w_held_q | w_hs);
  assign bvalid_d  = commit | (bvalid_q & ~s_axi.BREADY);
  assign rvalid_d  = ar_hs | (rvalid_q & ~s_axi.RREADY);
  assign wr_idx    = 32'(aw_held_q ? awidx_q : s_axi.AWADDR[ADDR_WIDTH-1:ADDR_LSB]);
  assign wr_data   = w_held_q ? wdata_q : s_axi.WDATA;
  assign wr_strb   = w_held_q ? wstrb_q : s_axi.WSTRB;
  assign rd_idx    = 32'(s_axi.ARADDR[ADDR_WIDTH-1:ADDR_LSB]);

  // Expand byte strobes into a bit mask.
  always_comb begin
    wr_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  // Write address decode and next register contents.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    wr_ok   = 1'b0;
`ifdef CTRL_REGS_IRQ_EN
    irq_en_d = irq_en_q;
    irq_clr  = '0;
`endif
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (wr_idx == k) begin
        wr_ok = 1'b1;
        if (commit) begin
          regs_d[k]  = (regs_q[k] & ~wr_mask) | (wr_data & wr_mask);
          pulse_d[k] = 1'b1;
        end
      end
    end
`ifdef CTRL_REGS_IRQ_EN
    if (wr_idx == IRQ_STAT_IDX) begin
      wr_ok = 1'b1;
      if (commit) irq_clr = wr_data[IRQ_W-1:0] & wr_mask[IRQ_W-1:0];
    end
    if (wr_idx == IRQ_EN_IDX) begin
      wr_ok = 1'b1;
      if (commit) irq_en_d = (irq_en_q & ~wr_mask[IRQ_W-1:0]) |
                             (wr_data[IRQ_W-1:0] & wr_mask[IRQ_W-1:0]);
    end
`endif
  end

  // Read address decode; status words are sampled here at AR acceptance.
  always_comb begin
    rd_data = '0;
    rd_ok   = 1'b0;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (rd_idx == k) begin
        rd_data = regs_q[k];
        rd_ok   = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_RO; k++) begin
      if (rd_idx == NUM_RW + k) begin
        rd_data = status_in[k*DATA_WIDTH +: DATA_WIDTH];
        rd_ok   = 1'b1;
      end
    end
`ifdef CTRL_REGS_IRQ_EN
    if (rd_idx == IRQ_STAT_IDX) begin
      rd_data = DATA_WIDTH'(irq_stat_q);
      rd_ok   = 1'b1;
    end
    if (rd_idx == IRQ_EN_IDX) begin
      rd_data = DATA_WIDTH'(irq_en_q);
      rd_ok   = 1'b1;
    end
`endif
  end

  // Control registers and their one-cycle commit pulses.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned k = 0; k < NUM_RW; k++) regs_q[k] <= '0;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
    end
  end

  // Write channel: beat capture, single outstanding write, B response.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      if (aw_hs) awidx_q <= s_axi.AWADDR[ADDR_WIDTH-1:ADDR_LSB];
      if (w_hs) begin
        wdata_q <= s_axi.WDATA;
        wstrb_q <= s_axi.WSTRB;
      end
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      bvalid_q  <= bvalid_d;
      if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel: single outstanding read, data held until R handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= ~rvalid_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

`ifdef CTRL_REGS_IRQ_EN
  // Interrupt status (set wins over W1C), enable, and registered request.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_src;
      irq_en_q   <= irq_en_d;
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end
  assign irq = irq_q;
`endif

  // Output ties.
  always_comb begin
    ctrl_out = '0;
    for (int unsigned k = 0; k < NUM_RW; k++) ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end
  assign ctrl_wr_pulse = pulse_q;
  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;
endmodule

// File: tb/tb_ctrl_regs_axil.sv
// Bench for ctrl_regs_axil: vector table, directed multi-cycle sequences and
// random traffic against a word/byte-level reference model.
module tb_ctrl_regs_axil;
  localparam int DW = 32, AW = 8, NRW = 8, NRO = 4, IW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_regs_axil_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  logic [NRW*DW-1:0] ctrl_out;
  logic [NRW-1:0]    pulse;
  logic [NRO*DW-1:0] status_in;
`ifdef CTRL_REGS_IRQ_EN
  logic [IW-1:0]     irq_src;
  logic              irq;
`endif

  ctrl_regs_axil #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO), .IRQ_W(IW)) dut (
    .ACLK(clk), .ARESETN(rst_n), .s_axi(bus), .ctrl_out(ctrl_out),
    .ctrl_wr_pulse(pulse), .status_in(status_in)
`ifdef CTRL_REGS_IRQ_EN
    , .irq_src(irq_src), .irq(irq)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_regs [NRW];
  int          m_pulses [NRW];
  logic [7:0]  m_irq_en;
  int          pulse_cnt [NRW];

  // Count every cycle each commit pulse is high
  always @(negedge clk) begin
    if (rst_n) for (int k = 0; k < NRW; k++) if (pulse[k]) pulse_cnt[k]++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    resp = 2'b10;
    if (idx < NRW) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
      m_pulses[idx]++;
      resp = 2'b00;
    end
`ifdef CTRL_REGS_IRQ_EN
    else if (idx == NRW + NRO) resp = 2'b00;
    else if (idx == NRW + NRO + 1) begin
      if (s[0]) m_irq_en = d[7:0];
      resp = 2'b00;
    end
`endif
  endtask

  task automatic m_read(input int idx, output logic [31:0] d, output logic [1:0] resp);
    d = 32'h0;
    resp = 2'b10;
    if (idx < NRW) begin
      d = m_regs[idx];
      resp = 2'b00;
    end else if (idx < NRW + NRO) begin
      d = status_in[(idx-NRW)*32 +: 32];
      resp = 2'b00;
    end
`ifdef CTRL_REGS_IRQ_EN
    else if (idx == NRW + NRO) resp = 2'b00;
    else if (idx == NRW + NRO + 1) begin
      d = {24'h0, m_irq_en};
      resp = 2'b00;
    end
`endif
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_delay, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    int n = 0;
    resp = 2'bxx;
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d;  bus.WSTRB = s; bus.WVALID = (w_delay == 0);
    bus.BREADY = 1'b1;
    while (!(aw_done && w_done)) begin
      if (n > 40) begin
        timeout("write_beats");
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        return;
      end
      if (bus.AWVALID && bus.AWREADY) aw_done = 1;
      if (bus.WVALID && bus.WREADY) w_done = 1;
      @(posedge clk); #1; n++;
      if (aw_done) bus.AWVALID = 1'b0;
      if (w_done) bus.WVALID = 1'b0;
      else if (n >= w_delay) bus.WVALID = 1'b1;
    end
    n = 0;
    while (!bus.BVALID) begin
      if (n > 40) begin timeout("write_resp"); return; end
      @(posedge clk); #1; n++;
    end
    resp = bus.BRESP;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    d = 'x; resp = 'x;
    bus.ARADDR = a; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    while (!bus.ARREADY) begin
      if (n > 40) begin timeout("read_addr"); bus.ARVALID = 1'b0; return; end
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID) begin
      if (n > 40) begin timeout("read_data"); return; end
      @(posedge clk); #1; n++;
    end
    d = bus.RDATA; resp = bus.RRESP;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [1:0]  r, er;
    logic [31:0] d, ed;
    int          idx;

    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
    bus.WDATA = '0;  bus.WSTRB = '0;  bus.WVALID = 0; bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;
    status_in = '0;
    status_in[31:0] = 32'hDEADBEEF;
`ifdef CTRL_REGS_IRQ_EN
    irq_src = '0;
`endif
    for (int k = 0; k < NRW; k++) begin m_regs[k] = '0; m_pulses[k] = 0; pulse_cnt[k] = 0; end
    m_irq_en = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    check("rst_valids", {bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}, 6'h0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_ctrl_out", ctrl_out[255:0] == '0, 1);
    check("rst_pulse", pulse, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

    // Vector table
    tbl.push_back('{8'h00, 32'h00000001, 4'hF, 2'b00, 32'h00000001, 2'b00});
    tbl.push_back('{8'h04, 32'h00000002, 4'hF, 2'b00, 32'h00000002, 2'b00});
    tbl.push_back('{8'h08, 32'h00000003, 4'hF, 2'b00, 32'h00000003, 2'b00});
    tbl.push_back('{8'h0C, 32'h00000004, 4'hF, 2'b00, 32'h00000004, 2'b00});
    tbl.push_back('{8'h08, 32'hAABBCCDD, 4'hF, 2'b00, 32'hAABBCCDD, 2'b00});
    tbl.push_back('{8'h08, 32'h11223344, 4'h5, 2'b00, 32'hAA22CC44, 2'b00});
    tbl.push_back('{8'h20, 32'h12345678, 4'hF, 2'b10, 32'hDEADBEEF, 2'b00});
    tbl.push_back('{8'hFC, 32'h87654321, 4'hF, 2'b10, 32'h00000000, 2'b10});
    tbl.push_back('{8'h0E, 32'h00000055, 4'h0, 2'b00, 32'h00000004, 2'b00});
    tbl.push_back('{8'h1C, 32'hFFFFFFFF, 4'h8, 2'b00, 32'hFF000000, 2'b00});
`ifdef CTRL_REGS_IRQ_EN
    tbl.push_back('{8'h30, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h00000000, 2'b00});
    tbl.push_back('{8'h34, 32'h000001FF, 4'hF, 2'b00, 32'h000000FF, 2'b00});
`else
    tbl.push_back('{8'h30, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h00000000, 2'b10});
    tbl.push_back('{8'h34, 32'h000001FF, 4'hF, 2'b10, 32'h00000000, 2'b10});
`endif
    foreach (tbl[i]) begin
      axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, r);
      m_write(int'(tbl[i].addr[7:2]), tbl[i].data, tbl[i].strb, er);
      check($sformatf("tbl%0d_bresp", i), r, tbl[i].bresp);
      axi_read(tbl[i].addr, d, r);
      check($sformatf("tbl%0d_rdata", i), d, tbl[i].rdata);
      check($sformatf("tbl%0d_rresp", i), r, tbl[i].rresp);
    end
    for (int k = 0; k < NRW; k++) begin
      check($sformatf("pulse_cycles%0d", k), pulse_cnt[k], m_pulses[k]);
      check($sformatf("ctrl_out%0d", k), ctrl_out[k*32 +: 32], m_regs[k]);
    end

    // AW first, W three cycles later, B held off for five cycles
    bus.AWADDR = 8'h10; bus.AWVALID = 1'b1; bus.BREADY = 1'b0;
    check("late_w_awready", bus.AWREADY, 1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    check("late_w_aw_dropped", bus.AWREADY, 0);
    repeat (2) @(posedge clk);
    #1;
    check("late_w_no_b_yet", bus.BVALID, 0);
    bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    m_write(4, 32'h0BADF00D, 4'hF, er);
    check("late_w_bvalid", bus.BVALID, 1);
    check("late_w_value", ctrl_out[4*32 +: 32], 32'h0BADF00D);
    check("late_w_pulse", pulse[4], 1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bhold%0d", c), {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, 5'b10000);
      @(posedge clk); #1;
    end
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    check("bhold_released", bus.BVALID, 0);
    @(posedge clk); #1;
    check("bhold_awready_back", bus.AWREADY, 1);

    // Read and write to the same register accepted together: old value returned
    ed = m_regs[5];
    bus.AWADDR = 8'h14; bus.AWVALID = 1'b1; bus.WDATA = 32'hCAFE0005; bus.WSTRB = 4'hF;
    bus.WVALID = 1'b1; bus.ARADDR = 8'h14; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    check("same_cycle_rvalid", {bus.RVALID, bus.BVALID}, 2'b11);
    check("same_cycle_old_data", bus.RDATA, ed);
    m_write(5, 32'hCAFE0005, 4'hF, er);
    @(posedge clk); #1;
    axi_read(8'h14, d, r);
    check("same_cycle_new_data", d, 32'hCAFE0005);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      idx = int'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        axi_write(8'(idx*4 + int'($urandom_range(0, 3))), d, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), r);
        m_write(idx, d, bus.WSTRB, er);
        check($sformatf("rnd%0d_bresp", i), r, er);
      end else begin
        status_in[$urandom_range(0, NRO-1)*32 +: 32] = $urandom;
        axi_read(8'(idx*4), d, r);
        m_read(idx, ed, er);
        check($sformatf("rnd%0d_rdata", i), d, ed);
        check($sformatf("rnd%0d_rresp", i), r, er);
      end
    end
    for (int k = 0; k < NRW; k++) check($sformatf("rnd_pulse_cycles%0d", k), pulse_cnt[k], m_pulses[k]);

    // Reset between AW handshake and W beat
    bus.AWADDR = 8'h18; bus.AWVALID = 1'b1; bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bvalid", bus.BVALID, 0);
    check("midrst_readies", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b000);
    check("midrst_regs_clear", ctrl_out[255:0] == '0, 1);
    for (int k = 0; k < NRW; k++) m_regs[k] = '0;
    m_irq_en = '0;
    @(posedge clk); #1;
    bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_b", bus.BVALID, 0);
    axi_write(8'h18, 32'h600D0006, 4'hF, 1, r);
    m_write(6, 32'h600D0006, 4'hF, er);
    check("midrst_fresh_bresp", r, 2'b00);
    axi_read(8'h18, d, r);
    check("midrst_fresh_rdata", d, 32'h600D0006);

`ifdef CTRL_REGS_IRQ_EN
    // Interrupt status / enable / W1C
    axi_write(8'h34, 32'h1, 4'hF, 0, r);
    check("irq_en_bresp", r, 2'b00);
    irq_src = 8'h01;
    @(posedge clk); #1;
    irq_src = 8'h00;
    @(posedge clk); #1;
    check("irq_assert", irq, 1);
    axi_read(8'h30, d, r);
    check("irq_status_read", d, 32'h1);
    axi_write(8'h30, 32'h1, 4'hF, 0, r);
    @(posedge clk); #1;
    check("irq_cleared", irq, 0);
    irq_src = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    check("irq_held_src", irq, 1);
    axi_write(8'h30, 32'h1, 4'hF, 0, r);
    @(posedge clk); #1;
    check("irq_set_wins", irq, 1);
    axi_read(8'h30, d, r);
    check("irq_status_kept", d, 32'h1);
    irq_src = 8'h00;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
